// File: rtl/tdm_demux_1x4_if.sv
// Bus bundle for the 4-slot TDM receive block: shared input lane plus the
// per-channel frame outputs and status. The frame_cnt signal exists only when
// FRAME_CNT_EN is defined.
interface tdm_demux_1x4_if #(
  parameter int unsigned DATA_W = 8
`ifdef FRAME_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              frame_sync;
  logic [DATA_W-1:0] Y0;
  logic [DATA_W-1:0] Y1;
  logic [DATA_W-1:0] Y2;
  logic [DATA_W-1:0] Y3;
  logic              frame_valid;
  logic              locked;
  logic [1:0]        slot;
  logic              sync_err;
`ifdef FRAME_CNT_EN
  logic [CNT_W-1:0]  frame_cnt;
`endif

  // Link-side driver of the TDM lane
  modport master (
    output din, din_valid, frame_sync,
    input  Y0, Y1, Y2, Y3, frame_valid, locked, slot, sync_err
`ifdef FRAME_CNT_EN
    ,
    input  frame_cnt
`endif
  );

  // Demux block
  modport slave (
    input  din, din_valid, frame_sync,
    output Y0, Y1, Y2, Y3, frame_valid, locked, slot, sync_err
`ifdef FRAME_CNT_EN
    ,
    output frame_cnt
`endif
  );

endinterface

// File: rtl/tdm_demux_1x4.sv
// 4-slot TDM receive demultiplexer. Locks onto frame_sync, stages channels
// 0..2 and publishes all four channel words together when slot 3 arrives.
// Optional feature: define FRAME_CNT_EN to add the frame_cnt output.
module tdm_demux_1x4 #(
  parameter int unsigned DATA_W = 8
`ifdef FRAME_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  tdm_demux_1x4_if.slave      bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state;
  logic [1:0]        slot_q;
  logic [DATA_W-1:0] ch0_q;
  logic [DATA_W-1:0] ch1_q;
  logic [DATA_W-1:0] ch2_q;
  logic [DATA_W-1:0] y0_q;
  logic [DATA_W-1:0] y1_q;
  logic [DATA_W-1:0] y2_q;
  logic [DATA_W-1:0] y3_q;
  logic              frame_valid_q;
  logic              sync_err_q;
  logic              locked_q;
`ifdef FRAME_CNT_EN
  logic [CNT_W-1:0]  frame_cnt_q;
`endif

  // Framing FSM, slot steering, staging and frame publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      slot_q        <= 2'd0;
      ch0_q         <= '0;
      ch1_q         <= '0;
      ch2_q         <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
`ifdef FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            // Unsynced beats are silently dropped while hunting
            if (bus.frame_sync) begin
              ch0_q    <= bus.din;
              slot_q   <= 2'd1;
              state    <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (slot_q == 2'd0) begin
              if (bus.frame_sync) begin
                ch0_q  <= bus.din;
                slot_q <= 2'd1;
              end else begin
                // Missing sync where slot 0 was due: lose lock
                sync_err_q <= 1'b1;
                slot_q     <= 2'd0;
                state      <= HUNT;
                locked_q   <= 1'b0;
              end
            end else if (bus.frame_sync) begin
              // Early sync: abandon partial frame, restart at slot 0
              sync_err_q <= 1'b1;
              ch0_q      <= bus.din;
              slot_q     <= 2'd1;
            end else begin
              case (slot_q)
                2'd1:    ch1_q <= bus.din;
                2'd2:    ch2_q <= bus.din;
                default: begin
                  // Slot 3 bypasses staging so the frame lands in one edge
                  y0_q          <= ch0_q;
                  y1_q          <= ch1_q;
                  y2_q          <= ch2_q;
                  y3_q          <= bus.din;
                  frame_valid_q <= 1'b1;
`ifdef FRAME_CNT_EN
                  frame_cnt_q   <= frame_cnt_q + CNT_W'(1);
`endif
                end
              endcase
              slot_q <= slot_q + 2'd1;
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
            slot_q   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.Y0          = y0_q;
  assign bus.Y1          = y1_q;
  assign bus.Y2          = y2_q;
  assign bus.Y3          = y3_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = locked_q;
  assign bus.slot        = slot_q;
  assign bus.sync_err    = sync_err_q;
`ifdef FRAME_CNT_EN
  assign bus.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: directed framing scenarios plus random traffic,
// checked by a queue-based frame model and a scoreboard monitor.
module tb_tdm_demux_1x4;

  localparam int unsigned DATA_W = 8;
`ifdef FRAME_CNT_EN
  localparam int unsigned CNT_W  = 2;
`endif

  logic clk;
  logic rst;

`ifdef FRAME_CNT_EN
  tdm_demux_1x4_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  tdm_demux_1x4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  tdm_demux_1x4_if #(.DATA_W(DATA_W)) bus ();
  tdm_demux_1x4 #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the beats of the frame being collected, in arrival order
  logic [DATA_W-1:0]   cur[$];
  logic [4*DATA_W-1:0] exp_q[$];
  logic [4*DATA_W-1:0] m_y;
  bit                  m_locked;
  bit                  m_err;
  bit                  m_fv;
  int                  m_frames;
  int                  n_exp_err;
  int                  n_obs_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    exp_q.delete();
    m_y      = '0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_fv     = 1'b0;
    m_frames = 0;
  endtask

  // Apply the framing rules to one clock cycle of input
  task automatic model_step(input bit v, input logic [DATA_W-1:0] d, input bit s);
    m_err = 1'b0;
    m_fv  = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          cur.delete();
          cur.push_back(d);
          m_locked = 1'b1;
        end
      end else if (cur.size() == 0) begin
        if (s) cur.push_back(d);
        else begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end
      end else if (s) begin
        m_err = 1'b1;
        cur.delete();
        cur.push_back(d);
      end else begin
        cur.push_back(d);
        if (cur.size() == 4) begin
          m_y = {cur[0], cur[1], cur[2], cur[3]};
          exp_q.push_back(m_y);
          m_fv = 1'b1;
          m_frames++;
          cur.delete();
        end
      end
      if (m_err) n_exp_err++;
    end
  endtask

  function automatic int exp_slot();
    return m_locked ? cur.size() : 0;
  endfunction

  // One clock cycle of stimulus; model advances at the same edge as the DUT
  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit s);
    @(negedge clk);
    bus.din_valid  = v;
    bus.din        = d;
    bus.frame_sync = s;
    @(posedge clk);
    model_step(v, d, s);
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input bit s);
    cyc(1'b1, d, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, DATA_W'($urandom), 1'($urandom));
  endtask

  // Asynchronous reset landing mid-cycle, away from any clock edge
  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.din_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_y", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'd0);
    check("reset_flags", 64'({bus.frame_valid, bus.locked, bus.slot, bus.sync_err}), 64'd0);
`ifdef FRAME_CNT_EN
    check("reset_frame_cnt", 64'(bus.frame_cnt), 64'd0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: pops an expected frame whenever frame_valid is seen
  initial begin
    logic [4*DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.sync_err) n_obs_err++;
        check("sync_err", 64'(bus.sync_err), 64'(m_err));
        check("locked", 64'(bus.locked), 64'(m_locked));
        check("slot", 64'(bus.slot), 64'(exp_slot()));
        check("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
        check("y_hold", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'(m_y));
`ifdef FRAME_CNT_EN
        check("frame_cnt", 64'(bus.frame_cnt), 64'(m_frames % (1 << CNT_W)));
`endif
        if (bus.frame_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'hDEAD_BEEF_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("frame_words", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    n_exp_err      = 0;
    n_obs_err      = 0;
    model_reset();
    #1;
    check("init_y", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'd0);
    check("init_flags", 64'({bus.frame_valid, bus.locked, bus.slot, bus.sync_err}), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    // Back-to-back frame straight out of reset
    beat(8'hA0, 1'b1); beat(8'hB1, 1'b0); beat(8'hC2, 1'b0); beat(8'hD3, 1'b0);
    idle(2);
    check("t1_y", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'hA0B1C2D3);

    // Hunt ignores unsynced beats; lock then frame
    do_reset();
    beat(8'h11, 1'b0); beat(8'h22, 1'b0);
    beat(8'h01, 1'b1); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    idle(1);
    check("t2_y", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'h01020304);
    check("t2_no_err", 64'(n_obs_err), 64'd0);

    // Stalls of 0..3 cycles between beats
    beat(8'h10, 1'b1); idle(0);
    beat(8'h20, 1'b0); idle(1);
    beat(8'h30, 1'b0); idle(2);
    beat(8'h40, 1'b0); idle(3);
    check("t3_y", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'h10203040);

    // Early sync mid-frame restarts the frame
    beat(8'h55, 1'b1); beat(8'h66, 1'b0); beat(8'h77, 1'b1);
    idle(1);
    check("t4_slot", 64'(bus.slot), 64'd1);
    beat(8'h88, 1'b0); beat(8'h99, 1'b0); beat(8'hAA, 1'b0);
    idle(1);
    check("t4_y", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'h778899AA);

    // Missing sync at slot 0 loses lock, Y held, then relock
    beat(8'h5A, 1'b0);
    idle(1);
    check("t5_unlocked", 64'(bus.locked), 64'd0);
    beat(8'hC0, 1'b1); beat(8'hC1, 1'b0); beat(8'hC2, 1'b0); beat(8'hC3, 1'b0);
    idle(1);
    check("t5_y", 64'({bus.Y0, bus.Y1, bus.Y2, bus.Y3}), 64'hC0C1C2C3);

    // Reset two beats into a frame
    beat(8'hE0, 1'b1); beat(8'hE1, 1'b0);
    do_reset();

`ifdef FRAME_CNT_EN
    // Counter advance and wrap with a 2-bit counter
    for (int f = 0; f < 4; f++) begin
      beat(8'(f), 1'b1); beat(8'h21, 1'b0); beat(8'h22, 1'b0); beat(8'h23, 1'b0);
      if (f == 2) begin
        idle(1);
        check("t6_cnt3", 64'(bus.frame_cnt), 64'd3);
      end
    end
    idle(1);
    check("t6_cnt_wrap", 64'(bus.frame_cnt), 64'd0);
`endif

    // Random traffic: mostly well-formed frames with stalls and stray syncs
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit s;
      v = ($urandom_range(0, 99) < 70);
      if (exp_slot() == 0) s = ($urandom_range(0, 99) < 88);
      else                 s = ($urandom_range(0, 99) < 6);
      cyc(v, DATA_W'($urandom), s);
    end
    idle(3);

    check("pending_frames", 64'(exp_q.size()), 64'd0);
    check("sync_err_total", 64'(n_obs_err), 64'(n_exp_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
